gravador_sequencia: RTL

//  Writer side of the PlaySeq sequence memory: captures player button presses
//  and stores them as one-hot codes in an internal synchronous 16x4 RAM.
//  The sync read port matches the pre-programmed ROM's timing (1-cycle

---
 rtl/gravador_sequencia.sv | 109 ++++++++++
 1 files changed

// File: rtl/gravador_sequencia.sv
// Writer side of the PlaySeq sequence memory: records one-hot button codes into a
// 2**ADDR_W x DATA_W sync RAM. Optional RECORD_ONEHOT_CHECK_EN rejects multi-button presses.
module gravador_sequencia #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic [ADDR_W-1:0] limite,
    input  logic [DATA_W-1:0] botoes,
    input  logic [ADDR_W-1:0] rd_address,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] wr_address,
    output logic              gravando,
    output logic              jogada,
    output logic              pronto,
    output logic              erro
);

    typedef enum logic [1:0] {S_INICIAL, S_ESPERA, S_SOLTA, S_FIM} state_t;

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic              ultimo, ultimo_nx;
    logic              we, jogada_nx, erro_nx, aceito;

    logic [DATA_W-1:0] mem [2**ADDR_W];

`ifdef RECORD_ONEHOT_CHECK_EN
    assign aceito = ((botoes & (botoes - DATA_W'(1))) == '0);
`else
    assign aceito = 1'b1;
`endif

    always_comb begin
        state_nx  = state;
        addr_nx   = wr_address;
        ultimo_nx = ultimo;
        we        = 1'b0;
        jogada_nx = 1'b0;
        erro_nx   = 1'b0;
        // iniciar restarts from any state and wins over a simultaneous press
        if (iniciar) begin
            state_nx  = S_ESPERA;
            addr_nx   = '0;
            ultimo_nx = 1'b0;
        end else begin
            case (state)
                S_ESPERA: begin
                    if (botoes != '0) begin
                        state_nx = S_SOLTA;
                        if (aceito) begin
                            we        = 1'b1;
                            jogada_nx = 1'b1;
                            if (wr_address != limite) addr_nx = wr_address + ADDR_W'(1);
                            else                      ultimo_nx = 1'b1;
                        end else begin
                            erro_nx = 1'b1;
                        end
                    end
                end
                S_SOLTA: begin
                    if (botoes == '0) state_nx = ultimo ? S_FIM : S_ESPERA;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_INICIAL;
            wr_address <= '0;
            ultimo     <= 1'b0;
            jogada     <= 1'b0;
        end else begin
            state      <= state_nx;
            wr_address <= addr_nx;
            ultimo     <= ultimo_nx;
            jogada     <= jogada_nx;
        end
    end

`ifdef RECORD_ONEHOT_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset) erro <= 1'b0;
        else       erro <= erro_nx;
    end
`else
    assign erro = 1'b0;
    logic unused_chk;
    assign unused_chk = erro_nx;
`endif

    // RAM is never cleared; nonblocking read gives old data on same-address write
    always_ff @(posedge clock) begin
        if (we && !reset) mem[wr_address] <= botoes;
    end

    always_ff @(posedge clock) begin
        if (reset) rd_data <= '0;
        else       rd_data <= mem[rd_address];
    end

    assign gravando = (state == S_ESPERA) || (state == S_SOLTA);
    assign pronto   = (state == S_FIM);

endmodule
